beidou_bit_word_decoder: RTL and testbench
==========================================

Name: beidou_bit_word_decoder

Overview:
- Parametrised successor to the single-threshold BeiDou bit decider.
- Takes per-epoch correlator energy results, makes a hard decision per epoch against a runtime threshold, and majority-votes VOTE_N epochs into one navigation bit.
- Packs WORD_W bits MSB-first into a navigation word.
- Sits between the correlator/energy accumulator and the frame-sync/parity block. Fully synchronous, single clock.

Parameters:
- ENERGY_W, 50: signed energy width.
- VOTE_N, 20: epochs per navigation bit (1 ms epochs, 20 ms D1 bit); must be >= 1.
- WORD_W, 30: bits per output word (D1 word length); must be >= 2.
- THRESH_RST, 15000000000: threshold register value after reset.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- flag, in, 1: tracking lock; decisions are made only while it is high.
- energy, in, ENERGY_W, signed: correlator energy, qualified by result_ok.
- result_ok, in, 1: one-cycle valid strobe for energy.
- thresh_wr, in, 1: load thresh_in into the threshold register.
- thresh_in, in, ENERGY_W, signed: new threshold value.
- decode_D, out, 1: most recent voted bit.
- bit_valid, out, 1: one-cycle pulse when decode_D updates.
- word_o, out, WORD_W: last completed word, first received bit in the MSB.
- word_valid, out, 1: one-cycle pulse when word_o updates.
- bit_cnt, out, clog2(WORD_W+1): bits held in the current partial word.
- lock_lost, out, 1: one-cycle pulse when a partial bit or word is discarded.

Behaviour:
- Reset (rst sampled high at posedge clk):
  - All outputs 0; thresh register = THRESH_RST; epoch and ones counters 0; shift register 0; state = IDLE.
  - rst overrides every other input in the same cycle.
- Epoch decision: e = (energy >= thresh), signed compare, so negative energy always gives 0. An energy exactly equal to the threshold gives 1.
- Threshold write:
  - thresh_wr takes effect the next cycle.
  - A result_ok in the same cycle as thresh_wr compares against the OLD threshold.
- State machine (2 states):
  - IDLE: result_ok is ignored. Go to ACC when flag = 1.
  - ACC: each cycle with result_ok = 1 and flag = 1, epoch_cnt += 1 and ones_cnt += e.
- Bit completion (on the VOTE_N-th accepted epoch):
  - bit = (2*ones_cnt_incl_this_epoch > VOTE_N). A tie (even VOTE_N) gives 0.
  - Counters clear in that cycle.
  - decode_D and bit_valid register on the next edge, i.e. 1-cycle latency from the final result_ok.
  - The bit shifts into the word register LSB side (shift left), so the first bit ends up in the MSB. bit_cnt increments.
- Word completion:
  - On the WORD_W-th bit, word_o loads the full shifted value and word_valid pulses in the same cycle as bit_valid.
  - bit_cnt returns to 0 and the shift register clears.
  - word_o holds until the next word completes.
- Back-to-back: result_ok on consecutive cycles is legal; there are no stalls and no backpressure.
- Loss of lock (flag = 0 while in ACC):
  - Return to IDLE and clear epoch_cnt, ones_cnt, the shift register and bit_cnt.
  - lock_lost pulses for one cycle only if epoch_cnt != 0 or bit_cnt != 0.
  - decode_D and word_o keep their last values.
- A result_ok in the same cycle that flag falls is discarded.
- Counter widths: clog2(VOTE_N+1). No wrap is possible because the counters clear at VOTE_N.

Optional Feature:
- Macro: DECODE_SOFT_CONF_EN.
- Defined:
  - Adds output soft_conf, width clog2(VOTE_N+1), registered alongside decode_D.
  - Value = |2*ones - VOTE_N| / 2, rounded down: agreement margin of the vote.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package beidou_pkg holds:
  - ENERGY_W_DEF;
  - D1 constants (VOTE_N_D1 = 20, WORD_W_D1 = 30);
  - THRESH_DEF;
  - the state enum {IDLE, ACC}.
- One natural sub-module: beidou_bit_vote, covering the epoch compare, counters and majority decision, with outputs bit plus strobe.
- The top level adds the word packer, the lock handling and the threshold register.

Test Plan:
- Reset then flag = 1 with 20 epochs of energy 2e10 (threshold 1.5e10) -> one bit_valid, decode_D = 1, exactly 1 cycle after the 20th result_ok.
- 10 epochs at 2e10 plus 10 at 1e10 (tie) -> decode_D = 0. Then 11 high plus 9 low -> decode_D = 1. Energy exactly 1.5e10 counts as 1; energy -5 counts as 0.
- 30 bits with pattern 0x2AAAAAAA -> word_valid pulses once with word_o = 30'h2AAAAAAA, bit_cnt returns to 0, and the word_valid and bit_valid pulses coincide.
- flag drops after 7 epochs of bit 4 -> lock_lost pulses, bit_cnt = 0; a later full word reassembles correctly from its first bit. flag drops in IDLE -> no lock_lost.
- thresh_wr = 1 with thresh_in = 3e10 together with result_ok at energy 2e10 -> that epoch scores 1; subsequent 2e10 epochs score 0.
- rst asserted mid-word and mid-bit -> all outputs 0 next cycle, threshold back to 1.5e10. With DECODE_SOFT_CONF_EN, a vote of 20/20 -> soft_conf = 10, and 10/20 -> soft_conf = 0.

Source files
------------

// File: rtl/beidou_pkg.sv
// Shared constants and state type for the BeiDou bit/word decoder.
package beidou_pkg;
  localparam int     ENERGY_W_DEF = 50;
  localparam int     VOTE_N_D1    = 20;
  localparam int     WORD_W_D1    = 30;
  localparam longint THRESH_DEF   = 64'sd15000000000;

  typedef enum logic {IDLE, ACC} state_t;
endpackage

// File: rtl/beidou_bit_vote.sv
// Per-epoch threshold decision and VOTE_N-epoch majority vote.
// The vote result is combinational on the final accepted epoch; the caller registers it.
module beidou_bit_vote
  import beidou_pkg::*;
#(
  parameter int ENERGY_W = ENERGY_W_DEF,
  parameter int VOTE_N   = VOTE_N_D1,
  localparam int CW      = $clog2(VOTE_N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [ENERGY_W-1:0] energy,
  input  logic signed [ENERGY_W-1:0] thresh,
  output logic                       vote_bit,
  output logic                       strobe,
  output logic                       busy
`ifdef DECODE_SOFT_CONF_EN
  ,
  output logic [CW-1:0]              margin
`endif
);
  localparam logic [CW-1:0] LAST = CW'(VOTE_N - 1);

  logic [CW-1:0] epoch_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] ones_next;
  logic          hit;
  int            twice;

  always_comb begin
    hit       = (energy >= thresh);
    ones_next = ones_cnt + CW'(hit);
    twice     = 2 * int'(ones_next);
    strobe    = en && (epoch_cnt == LAST);
    vote_bit  = (twice > VOTE_N);
    busy      = (epoch_cnt != '0);
  end

`ifdef DECODE_SOFT_CONF_EN
  assign margin = CW'(((twice >= VOTE_N) ? (twice - VOTE_N) : (VOTE_N - twice)) / 2);
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      epoch_cnt <= '0;
      ones_cnt  <= '0;
    end else if (en) begin
      if (strobe) begin
        epoch_cnt <= '0;
        ones_cnt  <= '0;
      end else begin
        epoch_cnt <= epoch_cnt + 1'b1;
        ones_cnt  <= ones_next;
      end
    end
  end
endmodule

// File: rtl/beidou_bit_word_decoder.sv
// Voted BeiDou navigation bits packed MSB-first into WORD_W-bit words, with lock-loss handling.
// Optional soft_conf vote-margin output under DECODE_SOFT_CONF_EN.
module beidou_bit_word_decoder
  import beidou_pkg::*;
#(
  parameter int ENERGY_W = ENERGY_W_DEF,
  parameter int VOTE_N   = VOTE_N_D1,
  parameter int WORD_W   = WORD_W_D1,
  parameter logic signed [ENERGY_W-1:0] THRESH_RST = ENERGY_W'(THRESH_DEF),
  localparam int BW      = $clog2(WORD_W + 1),
  localparam int CW      = $clog2(VOTE_N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flag,
  input  logic signed [ENERGY_W-1:0] energy,
  input  logic                       result_ok,
  input  logic                       thresh_wr,
  input  logic signed [ENERGY_W-1:0] thresh_in,
  output logic                       decode_D,
  output logic                       bit_valid,
  output logic [WORD_W-1:0]          word_o,
  output logic                       word_valid,
  output logic [BW-1:0]              bit_cnt,
  output logic                       lock_lost
`ifdef DECODE_SOFT_CONF_EN
  ,
  output logic [CW-1:0]              soft_conf
`endif
);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

  state_t                     state;
  logic signed [ENERGY_W-1:0] thresh;
  logic [WORD_W-2:0]          shreg;
  logic                       accept;
  logic                       drop;
  logic                       vote_bit;
  logic                       vote_strobe;
  logic                       vote_busy;
`ifdef DECODE_SOFT_CONF_EN
  logic [CW-1:0]              vote_margin;
`endif

  // An epoch arriving while flag falls is discarded along with the partial bit.
  assign drop   = (state == ACC) && !flag;
  assign accept = (state == ACC) && flag && result_ok;

  beidou_bit_vote #(
    .ENERGY_W (ENERGY_W),
    .VOTE_N   (VOTE_N)
  ) u_vote (
    .clk      (clk),
    .rst      (rst),
    .clr      (drop),
    .en       (accept),
    .energy   (energy),
    .thresh   (thresh),
    .vote_bit (vote_bit),
    .strobe   (vote_strobe),
    .busy     (vote_busy)
`ifdef DECODE_SOFT_CONF_EN
    ,
    .margin   (vote_margin)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      thresh     <= THRESH_RST;
      shreg      <= '0;
      bit_cnt    <= '0;
      decode_D   <= 1'b0;
      bit_valid  <= 1'b0;
      word_o     <= '0;
      word_valid <= 1'b0;
      lock_lost  <= 1'b0;
`ifdef DECODE_SOFT_CONF_EN
      soft_conf  <= '0;
`endif
    end else begin
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      lock_lost  <= 1'b0;
      if (thresh_wr) thresh <= thresh_in;
      case (state)
        IDLE: if (flag) state <= ACC;
        ACC: begin
          if (!flag) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            lock_lost <= vote_busy || (bit_cnt != '0);
          end else if (vote_strobe) begin
            decode_D  <= vote_bit;
            bit_valid <= 1'b1;
`ifdef DECODE_SOFT_CONF_EN
            soft_conf <= vote_margin;
`endif
            if (bit_cnt == LAST_BIT) begin
              word_o     <= {shreg, vote_bit};
              word_valid <= 1'b1;
              shreg      <= '0;
              bit_cnt    <= '0;
            end else begin
              shreg   <= (WORD_W-1)'({shreg, vote_bit});
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_beidou_bit_word_decoder.sv
// Randomized and directed bench for beidou_bit_word_decoder against a queue-based reference model.
module tb_beidou_bit_word_decoder;
  localparam int EW = 50;
  localparam int VN = 20;
  localparam int WW = 30;
  localparam int BW = $clog2(WW + 1);
`ifdef DECODE_SOFT_CONF_EN
  localparam int CW = $clog2(VN + 1);
`endif
  localparam logic signed [EW-1:0] T_RST = 50'sd15000000000;
  localparam logic signed [EW-1:0] T_NEW = 50'sd30000000000;
  localparam logic signed [EW-1:0] E_HI  = 50'sd20000000000;
  localparam logic signed [EW-1:0] E_LO  = 50'sd10000000000;
  localparam logic signed [EW-1:0] E_TOP = 50'sd40000000000;
  localparam logic signed [EW-1:0] E_NEG = -50'sd5;

  logic clk = 1'b0;
  logic rst, flag, result_ok, thresh_wr;
  logic signed [EW-1:0] energy, thresh_in;
  logic decode_D, bit_valid, word_valid, lock_lost;
  logic [WW-1:0] word_o;
  logic [BW-1:0] bit_cnt;
`ifdef DECODE_SOFT_CONF_EN
  logic [CW-1:0] soft_conf;
`endif

  always #5 clk = ~clk;

  beidou_bit_word_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .flag       (flag),
    .energy     (energy),
    .result_ok  (result_ok),
    .thresh_wr  (thresh_wr),
    .thresh_in  (thresh_in),
    .decode_D   (decode_D),
    .bit_valid  (bit_valid),
    .word_o     (word_o),
    .word_valid (word_valid),
    .bit_cnt    (bit_cnt),
    .lock_lost  (lock_lost)
`ifdef DECODE_SOFT_CONF_EN
    ,
    .soft_conf  (soft_conf)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: epoch decisions and word bits kept as plain queues.
  logic signed [EW-1:0] m_thresh;
  bit   m_locked;
  int   epochs[$];
  int   wbits[$];
  int   ones, d;
  logic x_d, x_bv, x_wv, x_ll;
  logic [WW-1:0] x_word;
  int   x_cnt, x_soft;

  always @(posedge clk) begin
    if (rst) begin
      m_thresh = T_RST; m_locked = 1'b0;
      epochs.delete(); wbits.delete();
      x_d = 0; x_bv = 0; x_wv = 0; x_ll = 0; x_word = '0; x_cnt = 0; x_soft = 0;
    end else begin
      x_bv = 0; x_wv = 0; x_ll = 0;
      if (!m_locked) m_locked = flag;
      else if (!flag) begin
        x_ll = (epochs.size() != 0) || (wbits.size() != 0);
        epochs.delete(); wbits.delete();
        m_locked = 1'b0;
      end else if (result_ok) begin
        epochs.push_back((energy >= m_thresh) ? 1 : 0);
        if (epochs.size() == VN) begin
          ones = epochs.sum();
          epochs.delete();
          x_d  = (2 * ones > VN);
          x_bv = 1'b1;
          d = 2 * ones - VN;
          if (d < 0) d = -d;
          x_soft = d / 2;
          wbits.push_back(x_d ? 1 : 0);
          if (wbits.size() == WW) begin
            x_word = '0;
            foreach (wbits[i]) x_word = {x_word[WW-2:0], 1'(wbits[i])};
            x_wv = 1'b1;
            wbits.delete();
          end
        end
      end
      if (thresh_wr) m_thresh = thresh_in;
      x_cnt = wbits.size();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("decode_D",   decode_D,   x_d);
      chk("bit_valid",  bit_valid,  x_bv);
      chk("word_o",     word_o,     x_word);
      chk("word_valid", word_valid, x_wv);
      chk("bit_cnt",    bit_cnt,    x_cnt);
      chk("lock_lost",  lock_lost,  x_ll);
`ifdef DECODE_SOFT_CONF_EN
      chk("soft_conf",  soft_conf,  x_soft);
`endif
    end
  end

  task automatic cycw(input logic f, input logic ok, input logic signed [EW-1:0] e,
                      input logic tw, input logic signed [EW-1:0] ti);
    @(posedge clk); #1;
    flag = f; result_ok = ok; energy = e; thresh_wr = tw; thresh_in = ti;
  endtask

  task automatic cyc(input logic f, input logic ok, input logic signed [EW-1:0] e);
    cycw(f, ok, e, 1'b0, '0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0);
  endtask

  task automatic run(input int n, input logic signed [EW-1:0] e);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, e);
  endtask

  task automatic send_bit(input logic b);
    run(VN, b ? E_HI : E_LO);
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = WW - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  function automatic logic signed [EW-1:0] rnd_e();
    case ($urandom_range(0, 5))
      0: return E_HI;
      1: return E_LO;
      2: return T_RST;
      3: return T_RST + EW'($urandom_range(0, 20)) - 50'sd10;
      4: return -EW'($urandom);
      default: return EW'({$urandom, $urandom});
    endcase
  endfunction

  function automatic logic signed [EW-1:0] rnd_t();
    case ($urandom_range(0, 2))
      0: return T_RST;
      1: return T_NEW;
      default: return E_LO + EW'($urandom_range(0, 1000));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic fl;
    rst = 1'b1; flag = 1'b0; result_ok = 1'b0; energy = '0; thresh_wr = 1'b0; thresh_in = '0;
    cyc(1'b0, 1'b0, '0);
    chk_on = 1'b1;
    chk("rst_decode_D", decode_D, 0);
    chk("rst_word_o", word_o, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_lock_lost", lock_lost, 0);
    rst = 1'b0;
    idle();

    // First bit: 1-cycle latency after the 20th epoch
    run(VN, E_HI);
    chk("lat_early_bit_valid", bit_valid, 0);
    idle();
    chk("lat_bit_valid", bit_valid, 1);
    chk("lat_decode_D", decode_D, 1);
    chk("lat_bit_cnt", bit_cnt, 1);
`ifdef DECODE_SOFT_CONF_EN
    chk("soft_20of20", soft_conf, 10);
`endif
    idle();
    chk("bit_valid_pulse", bit_valid, 0);

    run(10, E_HI); run(10, E_LO); idle();
    chk("tie_decode_D", decode_D, 0);
`ifdef DECODE_SOFT_CONF_EN
    chk("soft_10of20", soft_conf, 0);
`endif
    run(11, E_HI); run(9, E_LO); idle();
    chk("maj11_decode_D", decode_D, 1);
    run(VN, T_RST); idle();
    chk("equal_thresh", decode_D, 1);
    run(VN, E_NEG); idle();
    chk("neg_energy", decode_D, 0);
    chk("bit_cnt_5", bit_cnt, 5);

    // Lock loss with a partial word, then a drop while already idle
    cyc(1'b0, 1'b0, '0); cyc(1'b0, 1'b0, '0);
    chk("ll_partial_word", lock_lost, 1);
    chk("ll_bit_cnt", bit_cnt, 0);
    cyc(1'b0, 1'b0, '0);
    chk("ll_idle", lock_lost, 0);

    idle();
    send_word(30'h2AAAAAAA); idle();
    chk("word_valid", word_valid, 1);
    chk("word_bit_valid", bit_valid, 1);
    chk("word_aaaa", word_o, 30'h2AAAAAAA);
    chk("word_bit_cnt", bit_cnt, 0);
    idle();
    chk("word_valid_pulse", word_valid, 0);

    // Drop lock 7 epochs into bit 4
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); run(7, E_HI);
    cyc(1'b0, 1'b0, '0); cyc(1'b0, 1'b0, '0);
    chk("ll_mid_bit", lock_lost, 1);
    chk("ll_mid_bit_cnt", bit_cnt, 0);
    chk("word_hold", word_o, 30'h2AAAAAAA);
    idle();
    send_word(30'h12345678); idle();
    chk("word_reassembled", word_o, 30'h12345678);

    // Threshold write compares the same-cycle epoch against the old value
    cycw(1'b1, 1'b1, E_HI, 1'b1, T_NEW);
    run(10, E_TOP); run(9, E_HI); idle();
    chk("thresh_old_epoch", decode_D, 1);
    run(10, E_TOP); run(10, E_HI); idle();
    chk("thresh_new_epochs", decode_D, 0);

    // Reset mid-word and mid-bit restores the default threshold
    send_bit(1'b1); send_bit(1'b1); run(5, E_HI);
    rst = 1'b1;
    cyc(1'b1, 1'b1, E_HI);
    chk("mid_rst_decode_D", decode_D, 0);
    chk("mid_rst_bit_cnt", bit_cnt, 0);
    chk("mid_rst_word_o", word_o, 0);
    rst = 1'b0;
    idle();
    run(VN, E_HI); idle();
    chk("thresh_restored", decode_D, 1);

    // Random phase A: continuous lock
    for (int i = 0; i < 4000; i++)
      cycw(1'b1, $urandom_range(0, 7) != 0, rnd_e(), $urandom_range(0, 199) == 0, rnd_t());

    // Random phase B: lock drops and occasional resets
    fl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (fl && $urandom_range(0, 149) == 0) fl = 1'b0;
      else if (!fl && $urandom_range(0, 4) == 0) fl = 1'b1;
      cycw(fl, $urandom_range(0, 3) != 0, rnd_e(), $urandom_range(0, 99) == 0, rnd_t());
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
